mem_bus_demux: RTL
==================

// Module: mem_bus_demux
// PURPOSE
//  Parametrised 1-master/N-slave decoder for the core's valid/ready memory bus; replaces ad-hoc
//  address-compare glue between core and rom/ram/gpio. Each slave claims an address window
//  (base/mask). The request is registered and sequenced by an FSM. Unmapped accesses and slave
//  timeouts get an error response, so the core never hangs. Records last error address and count.
// PARAMETERS
//  N_SLAVES   4                 number of slave channels (1..16)
//  ADDR_W     32                address width
//  DATA_W     32                data width, multiple of 8
//  SLV_BASE   {N_SLAVES{32'h0}} packed bases; slave i = SLV_BASE[i*ADDR_W +: ADDR_W]
//  SLV_MASK   {N_SLAVES{32'h0}} packed masks; slave i hit when (addr & MASK_i) == BASE_i
//  TIMEOUT    255               max cycles s_valid may wait for s_ready; 0 = no timeout
//  ERR_RDATA  32'hDEADBEEF      m_rdata returned on error responses
// PORTS
//  clk        in   1                 clock, rising edge
//  rst        in   1                 asynchronous active-high reset
//  m_valid    in   1                 master request; held until m_ready
//  m_ready    out  1                 one-cycle response strobe
//  m_addr     in   ADDR_W            master address
//  m_wdata    in   DATA_W            master write data
//  m_wstrb    in   DATA_W/8          byte strobes; 0 = read
//  m_rdata    out  DATA_W            read data, valid when m_ready=1
//  err        out  1                 high with m_ready on an unmapped or timed-out access
//  err_addr   out  ADDR_W            address of most recent error
//  err_count  out  16                error count, saturates at 16'hFFFF
//  s_valid    out  N_SLAVES          one-hot slave request
//  s_ready    in   N_SLAVES          slave completion; only the selected bit is sampled
//  s_addr     out  ADDR_W            registered address, broadcast to all slaves
//  s_wdata    out  DATA_W            registered write data, broadcast
//  s_wstrb    out  DATA_W/8          registered strobes, broadcast
//  s_rdata    in   N_SLAVES*DATA_W   packed slave read data
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timeout counter 0. Async assert mid-transaction drops
//   s_valid/m_ready immediately; the in-flight access is abandoned, with no response.
//  FSM states: IDLE, ACTIVE, RESP, ERR. All outputs are registered.
//  IDLE: on m_valid, latch addr/wdata/wstrb into s_*. Decode with the lowest matching index
//   winning on window overlap. Hit -> ACTIVE with sel latched; no hit -> ERR.
//  ACTIVE: s_valid[sel]=1, counter increments each cycle.
//   s_ready[sel]=1 -> capture s_rdata[sel] into m_rdata, go to RESP.
//   Else if TIMEOUT!=0 and counter==TIMEOUT-1 -> go to ERR; the slave access is dropped.
//  RESP: m_ready=1, err=0, s_valid=0 -> IDLE.
//  ERR: m_ready=1, err=1, m_rdata=ERR_RDATA, err_addr=s_addr, err_count+=1 (saturating) -> IDLE.
//   Writes to unmapped space are discarded.
//  Latency from m_valid sampled (cycle 0): s_valid from cycle 1. s_ready seen in cycle k gives
//   m_ready in cycle k+1, so the minimum is 2 cycles. Unmapped access gives m_ready in cycle 1.
//  Master drops m_valid on the edge where it samples m_ready. A new m_valid in IDLE the cycle
//   after RESP/ERR is accepted, giving back-to-back 1-cycle turnaround in IDLE.
//  m_valid falling in ACTIVE is a protocol error: it is ignored and the slave access completes.
//  Outside RESP/ERR, m_rdata holds its last value. s_addr/s_wdata/s_wstrb hold between requests.
//  Counter width is $clog2(TIMEOUT+1); it clears on entry to ACTIVE.
// TESTING (map: 0=ROM base 0x00050000, 1=RAM base 0x00000000, 2=GPIO base 0x03000000;
//  all masks 0xFFFF0000; TIMEOUT=8)
//  1 read 0x00050004, s_ready[0] in cycle 2, s_rdata0=0x00000013 -> s_valid=3'b001 in
//    cycles 1-2, m_ready in cycle 3, m_rdata=0x00000013, err=0
//  2 write 0x00000010 wdata 0xCAFEBABE wstrb 0xF, s_ready[1] in cycle 1 -> s_wdata=0xCAFEBABE,
//    s_wstrb=0xF, m_ready in cycle 2; back-to-back read in cycle 3 gets s_valid in cycle 4
//  3 read 0x04000000 (unmapped) -> s_valid never asserted, m_ready+err in cycle 1,
//    m_rdata=0xDEADBEEF, err_addr=0x04000000, err_count=1
//  4 read 0x03000000, GPIO never ready -> s_valid[2] high for exactly 8 cycles, then m_ready+err,
//    err_addr=0x03000000, err_count increments
//  5 rst pulse while in ACTIVE -> s_valid=0 and err_count=0 immediately; m_ready never pulses
//  6 overlapping windows (slave 3 = base 0x00050000, mask 0xFFFF0000) -> slave 0 selected;
//    force err_count=0xFFFF, then an unmapped access -> err_count stays 0xFFFF

Source files
------------

// File: rtl/mem_bus_demux_if.sv
// Valid/ready memory bus bundle between the core, mem_bus_demux and its slaves.
// The demux uses the slave modport; the core/slave environment uses master.
interface mem_bus_demux_if #(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic                       m_valid;
    logic                       m_ready;
    logic [ADDR_W-1:0]          m_addr;
    logic [DATA_W-1:0]          m_wdata;
    logic [DATA_W/8-1:0]        m_wstrb;
    logic [DATA_W-1:0]          m_rdata;
    logic                       err;

    logic [N_SLAVES-1:0]        s_valid;
    logic [N_SLAVES-1:0]        s_ready;
    logic [ADDR_W-1:0]          s_addr;
    logic [DATA_W-1:0]          s_wdata;
    logic [DATA_W/8-1:0]        s_wstrb;
    logic [N_SLAVES*DATA_W-1:0] s_rdata;

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        input  m_ready, m_rdata, err, s_valid, s_addr, s_wdata, s_wstrb
    );

    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, err, s_valid, s_addr, s_wdata, s_wstrb
    );
endinterface

// File: rtl/mem_bus_demux.sv
// 1-master/N-slave address decoder for the valid/ready memory bus, with error responses
// for unmapped addresses and slave timeouts plus a record of the last error.
module mem_bus_demux #(
    parameter int                         N_SLAVES  = 4,
    parameter int                         ADDR_W    = 32,
    parameter int                         DATA_W    = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE  = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK  = '0,
    parameter int                         TIMEOUT   = 255,
    parameter logic [DATA_W-1:0]          ERR_RDATA = DATA_W'(32'hDEADBEEF)
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_demux_if.slave    bus,
    output logic [ADDR_W-1:0] err_addr,
    output logic [15:0]       err_count
);
    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP, ERR} state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel;
    logic [CNT_W-1:0]   cnt;

    logic               dec_hit;
    logic [SEL_W-1:0]   dec_idx;
    logic               sel_ready;
    logic [DATA_W-1:0]  sel_rdata;
    logic [15:0]        err_count_inc;

    // Scanning from the top down lets the lowest matching window win on overlap.
    always_comb begin
        // NOTE: every signal gets a default before the loop so no path infers a latch.
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((bus.m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                dec_hit = 1'b1;
                dec_idx = SEL_W'(i);
            end
        end
    end

    assign sel_ready     = bus.s_ready[sel];
    assign sel_rdata     = bus.s_rdata[int'(sel)*DATA_W +: DATA_W];
    assign err_count_inc = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

    // NOTE: sequential state uses non-blocking (<=) so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= '0;
            cnt         <= '0;
            bus.m_ready <= 1'b0;
            bus.m_rdata <= '0;
            bus.err     <= 1'b0;
            bus.s_valid <= '0;
            bus.s_addr  <= '0;
            bus.s_wdata <= '0;
            bus.s_wstrb <= '0;
            err_addr    <= '0;
            err_count   <= '0;
        end else begin
            bus.m_ready <= 1'b0;
            bus.err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.m_valid) begin
                        bus.s_addr  <= bus.m_addr;
                        bus.s_wdata <= bus.m_wdata;
                        bus.s_wstrb <= bus.m_wstrb;
                        if (dec_hit) begin
                            sel         <= dec_idx;
                            cnt         <= '0;
                            bus.s_valid <= N_SLAVES'(1) << dec_idx;
                            state       <= ACTIVE;
                        end else begin
                            bus.m_ready <= 1'b1;
                            bus.err     <= 1'b1;
                            bus.m_rdata <= ERR_RDATA;
                            err_addr    <= bus.m_addr;
                            err_count   <= err_count_inc;
                            state       <= ERR;
                        end
                    end
                end
                ACTIVE: begin
                    if (sel_ready) begin
                        bus.s_valid <= '0;
                        bus.m_ready <= 1'b1;
                        bus.m_rdata <= sel_rdata;
                        state       <= RESP;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        // Slave gave up on: drop the request and answer the master with an error.
                        bus.s_valid <= '0;
                        bus.m_ready <= 1'b1;
                        bus.err     <= 1'b1;
                        bus.m_rdata <= ERR_RDATA;
                        err_addr    <= bus.s_addr;
                        err_count   <= err_count_inc;
                        state       <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
